// File: rtl/mem_burst_ctrl.sv
// ============================================================================
// Module      : mem_burst_ctrl
// Description : Burst request master for a single-port valid/ready memory.
//               It turns one command into sequential single-word accesses.
//               Define BURST_WRAP_EN to allow bursts that wrap past DEPTH-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_burst_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [WIDTH-1:0]      wd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_wr_rd,
  output logic [WIDTH-1:0]      m_wdata,
  output logic                  m_valid,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_FETCH = 3'd1,
    S_WR_REQ   = 3'd2,
    S_RD_REQ   = 3'd3,
    S_RD_OUT   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH+1:0] c_depth     = (ADDR_WIDTH+2)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ADDR_WIDTH:0]   r_len, w_len_nxt;
  logic [ADDR_WIDTH:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]      r_rd_data, w_rd_data_nxt;
  logic [WIDTH-1:0]      r_m_wdata, w_wdata_hold;
  logic                  w_err_nxt;

  logic                  r_cmd_ready, r_wd_ready, r_rd_valid, r_m_wr_rd, r_m_valid;
  logic                  r_busy, r_done, r_err;
  logic [ADDR_WIDTH-1:0] r_m_addr;

  logic [ADDR_WIDTH+1:0] w_end;
  logic                  w_len_bad, w_cmd_bad;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [ADDR_WIDTH:0]   w_cnt_inc;
  logic                  w_last;

  assign w_end     = {2'b00, cmd_addr} + {1'b0, cmd_len};
  assign w_len_bad = (cmd_len == '0) || ({1'b0, cmd_len} > c_depth);
`ifdef BURST_WRAP_EN
  assign w_cmd_bad = w_len_bad;
`else
  assign w_cmd_bad = w_len_bad || (w_end > c_depth);
`endif

  // Explicit wrap keeps the address modulo DEPTH even when DEPTH is not a power of two.
  assign w_addr_inc = (r_addr == c_last_addr) ? '0 : r_addr + 1'b1;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last     = (w_cnt_inc == r_len);

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_len_nxt     = r_len;
    w_cnt_nxt     = r_cnt;
    w_rd_data_nxt = r_rd_data;
    w_wdata_hold  = r_m_wdata;
    w_err_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_addr_nxt = cmd_addr;
          w_len_nxt  = cmd_len;
          w_cnt_nxt  = '0;
          if (w_cmd_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = cmd_wr_rd ? S_WR_FETCH : S_RD_REQ;
          end
        end
      end
      S_WR_FETCH: begin
        if (wd_valid) begin
          w_wdata_hold = wd_data;
          w_state_nxt  = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (m_ready) begin
          w_cnt_nxt   = w_cnt_inc;
          w_addr_nxt  = w_addr_inc;
          w_state_nxt = w_last ? S_DONE : S_WR_FETCH;
        end
      end
      S_RD_REQ: begin
        if (m_ready) begin
          w_rd_data_nxt = m_rdata;
          w_state_nxt   = S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        if (rd_ready) begin
          w_cnt_nxt   = w_cnt_inc;
          w_addr_nxt  = w_addr_inc;
          w_state_nxt = w_last ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so every port comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_rd_data   <= '0;
      r_m_wdata   <= '0;
      r_m_addr    <= '0;
      r_m_wr_rd   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_wd_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_len       <= w_len_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_m_wdata   <= (w_state_nxt == S_WR_REQ) ? w_wdata_hold : '0;
      r_m_addr    <= ((w_state_nxt == S_WR_REQ) || (w_state_nxt == S_RD_REQ)) ? w_addr_nxt : '0;
      r_m_wr_rd   <= (w_state_nxt == S_WR_REQ);
      r_m_valid   <= (w_state_nxt == S_WR_REQ) || (w_state_nxt == S_RD_REQ);
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_wd_ready  <= (w_state_nxt == S_WR_FETCH);
      r_rd_valid  <= (w_state_nxt == S_RD_OUT);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_err       <= w_err_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign wd_ready  = r_wd_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign m_addr    = r_m_addr;
  assign m_wr_rd   = r_m_wr_rd;
  assign m_wdata   = r_m_wdata;
  assign m_valid   = r_m_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
// ============================================================================
// Module      : tb_mem_burst_ctrl
// Description : Directed and randomized bench for mem_burst_ctrl with a
//               behavioural memory and a reference model of burst traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_burst_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_wr_rd;
  logic [AW-1:0]    cmd_addr;
  logic [AW:0]      cmd_len;
  logic             wd_valid, wd_ready;
  logic [WIDTH-1:0] wd_data;
  logic             rd_valid, rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    m_addr;
  logic             m_wr_rd, m_valid, m_ready;
  logic [WIDTH-1:0] m_wdata, m_rdata;
  logic             busy, done, err;

  mem_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .m_addr(m_addr), .m_wr_rd(m_wr_rd), .m_wdata(m_wdata), .m_valid(m_valid),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // mem is the memory device seen by the DUT; ref_mem is the model's view.
  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] wq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one memory access for dly stall cycles, then complete it.
  task automatic mem_req(input bit wr, input int a, input logic [WIDTH-1:0] data, input int dly);
    for (int i = 0; i <= dly; i++) begin
      chk("m_valid", m_valid, 1);
      chk("m_wr_rd", m_wr_rd, wr);
      chk("m_addr", m_addr, a);
      chk("m_wdata", m_wdata, wr ? data : '0);
      chk("wd_ready_req", wd_ready, 0);
      chk("rd_valid_req", rd_valid, 0);
      if (i == dly) begin
        m_ready   = 1'b1;
        wd_valid  = 1'b0;
        cmd_valid = 1'b0;
        if (wr) begin
          mem[m_addr] = m_wdata;
          ref_mem[a]  = data;
        end else begin
          m_rdata = mem[m_addr];
        end
      end else begin
        m_ready   = 1'b0;
        m_rdata   = WIDTH'($urandom);
        wd_valid  = 1'($urandom);
        wd_data   = WIDTH'($urandom);
        cmd_valid = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_len   = (AW+1)'($urandom_range(1, 4));
      end
      @(negedge clk);
    end
    m_ready   = 1'b0;
    wd_valid  = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // Issue one command and check every cycle against the burst model.
  task automatic run_cmd(input bit wr, input int addr, input int len,
                         input int mdly, input int rdly, input int abort_at);
    bit legal;
    int exp_a;
    int d;
    logic [WIDTH-1:0] w;
    legal = (len >= 1) && (len <= DEPTH);
`ifndef BURST_WRAP_EN
    legal = legal && (addr + len <= DEPTH);
`endif
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_wr_rd = wr;
    cmd_addr  = addr[AW-1:0];
    cmd_len   = len[AW:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!legal) begin
      chk("err_pulse", err, 1);
      chk("rej_busy", busy, 0);
      chk("rej_m_valid", m_valid, 0);
      chk("rej_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("rej_m_valid2", m_valid, 0);
      chk("rej_done", done, 0);
      return;
    end
    chk("err_none", err, 0);
    chk("busy", busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
    exp_a = addr % DEPTH;
    for (int k = 0; k < len; k++) begin
      if (wr) begin
        w = wq.pop_front();
        d = $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
          chk("wd_ready", wd_ready, 1);
          chk("fetch_m_valid", m_valid, 0);
          m_ready  = 1'($urandom);
          wd_valid = 1'b0;
          @(negedge clk);
        end
        chk("wd_ready", wd_ready, 1);
        chk("fetch_m_valid", m_valid, 0);
        wd_valid = 1'b1;
        wd_data  = w;
        m_ready  = 1'($urandom);
        @(negedge clk);
        wd_valid = 1'b0;
        m_ready  = 1'b0;
        wd_data  = WIDTH'($urandom);
        mem_req(1'b1, exp_a, w, mdly);
      end else begin
        if (k == abort_at) begin
          chk("abort_pre_m_valid", m_valid, 1);
          rst = 1'b0;
          @(negedge clk);
          rst = 1'b1;
          chk("abort_busy", busy, 0);
          chk("abort_m_valid", m_valid, 0);
          chk("abort_rd_valid", rd_valid, 0);
          chk("abort_cmd_ready", cmd_ready, 1);
          chk("abort_done", done, 0);
          repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
          end
          return;
        end
        mem_req(1'b0, exp_a, '0, mdly);
        for (int i = 0; i <= rdly; i++) begin
          chk("rd_valid", rd_valid, 1);
          chk("rd_data", rd_data, ref_mem[exp_a]);
          chk("out_m_valid", m_valid, 0);
          rd_ready = (i == rdly);
          @(negedge clk);
        end
        rd_ready = 1'b0;
      end
      exp_a = (exp_a + 1) % DEPTH;
    end
    chk("done_pulse", done, 1);
    chk("done_cmd_ready", cmd_ready, 0);
    chk("done_m_valid", m_valid, 0);
    chk("done_rd_valid", rd_valid, 0);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    int a, l;
    bit wr;
    rst = 1'b0; cmd_valid = 1'b0; cmd_wr_rd = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0; m_rdata = '0; m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_wd_ready", wd_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single word write then read back
    wq.push_back(8'hA5);
    run_cmd(1'b1, 15, 1, 0, 0, -1);
    run_cmd(1'b0, 15, 1, 0, 0, -1);

    // Five-word burst
    for (int i = 1; i <= 5; i++) wq.push_back(WIDTH'(i));
    run_cmd(1'b1, 20, 5, $urandom_range(0, 2), 0, -1);
    run_cmd(1'b0, 20, 5, $urandom_range(0, 2), $urandom_range(0, 2), -1);

    // Full-depth burst
    for (int i = 0; i < DEPTH; i++) wq.push_back(WIDTH'(i) ^ 8'h5A);
    run_cmd(1'b1, 0, DEPTH, 0, 0, -1);
    run_cmd(1'b0, 0, DEPTH, 0, 0, -1);

    // Boundary commands
    run_cmd(1'b1, 3, 0, 0, 0, -1);
    run_cmd(1'b0, 3, DEPTH + 1, 0, 0, -1);
    for (int i = 0; i < 4; i++) wq.push_back(WIDTH'($urandom));
    run_cmd(1'b1, 30, 4, 1, 0, -1);
    wq.delete();
    run_cmd(1'b0, 30, 4, 0, 1, -1);

    // Backpressure on both sides
    for (int i = 0; i < 6; i++) wq.push_back(WIDTH'($urandom));
    run_cmd(1'b1, 7, 6, 3, 0, -1);
    run_cmd(1'b0, 7, 6, 3, 4, -1);

    // Randomized legal bursts
    for (int n = 0; n < 8; n++) begin
      wr = 1'($urandom);
      l  = $urandom_range(1, 8);
      a  = $urandom_range(0, DEPTH - l);
      if (wr) for (int i = 0; i < l; i++) wq.push_back(WIDTH'($urandom));
      run_cmd(wr, a, l, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // Reset during the third word of an eight-word read, then recover
    run_cmd(1'b0, 0, 8, 1, 1, 2);
    run_cmd(1'b0, 20, 5, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
